// File: rtl/uart_tx_pkg.sv
`timescale 1ns/1ps
// uart_tx_pkg: shared types and constants for the serial transmitter.
// The PARITY state is always declared so the state encoding does not
// change between builds with and without UART_TX_PARITY_EN.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Level driven on the line whenever no start/data/parity bit is active.
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_block_timer.sv
`timescale 1ns/1ps
// tx_bit_timer: wrap counter 0..MAX-1 with enable and synchronous clear.
// wrap_o is a one-cycle strobe, high in the cycle the counter sits at
// MAX-1 while enabled (i.e. the cycle after which it returns to 0).
module tx_bit_timer #(
  parameter int unsigned MAX = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr_i,
  input  logic en_i,
  output logic wrap_o
);

  localparam int unsigned W = (MAX > 1) ? $clog2(MAX) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_max;

  assign at_max = (cnt_q == W'(MAX - 1));
  assign wrap_o = en_i && !clr_i && at_max;

  // Next count: clear wins, otherwise advance and roll over at MAX-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_max ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_block.sv
`timescale 1ns/1ps
// uart_tx_block: asynchronous serial transmitter (start, LSB-first data,
// optional even parity, stop). Build option UART_TX_PARITY_EN inserts the
// parity bit between the last data bit and the stop bit.
//
// Handshake: the client raises tx_start with tx_data valid; the request is
// taken in any cycle where tx_busy is low and ignored otherwise. tx_busy
// stays high for the whole frame and tx_done pulses for one cycle after the
// last stop-bit cycle, in which tx_busy is already low so a new request in
// that same cycle is accepted.
module uart_tx_block
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 serial_out
);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 serial_q, serial_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 bit_wrap;
  logic                 idx_wrap;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // Bit-period timer: free-runs through every non-idle state.
  tx_bit_timer #(.MAX(CLKS_PER_BIT)) u_bit_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr_i  (accept),
    .en_i   (state_q != IDLE),
    .wrap_o (bit_wrap)
  );

  // Bit index: advances once per completed data bit; its wrap marks the last one.
  tx_bit_timer #(.MAX(DATA_BITS)) u_bit_index (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr_i  (accept),
    .en_i   ((state_q == DATA) && bit_wrap),
    .wrap_o (idx_wrap)
  );

  // Next-state, shift register, done pulse and next line level.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    accept  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          accept  = 1'b1;
          shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
          state_d = START;
        end
      end
      START: begin
        if (bit_wrap) state_d = DATA;
      end
      DATA: begin
        if (bit_wrap) begin
          shift_d = shift_q >> 1;
          if (idx_wrap) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (bit_wrap) state_d = STOP;
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (bit_wrap) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The line level is registered, so it is derived from the state being entered.
    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_d = parity_d;
`endif
      default: serial_d = IDLE_LEVEL;
    endcase
  end

  // State, data and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      serial_q <= IDLE_LEVEL;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_busy    = (state_q != IDLE);
  assign tx_done    = done_q;
  assign serial_out = serial_q;

endmodule

// File: tb/tb_uart_tx_block.sv
`timescale 1ns/1ps
// tb_uart_tx_block: directed frames with hand-written expected line images.
// The driver pushes each expected frame (bit 0 = start bit, then data LSB
// first, optional parity, stop) into exp_q; an independent line monitor
// captures every frame it sees on serial_out and compares on completion.
module tb_uart_tx_block;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FW = 11;
  localparam logic [FW-1:0] F_A5 = 11'b1_0_10100101_0;
  localparam logic [FW-1:0] F_07 = 11'b1_1_00000111_0;
  localparam logic [FW-1:0] F_3C = 11'b1_0_00111100_0;
  localparam logic [FW-1:0] F_5A = 11'b1_0_01011010_0;
  localparam logic [FW-1:0] F_C1 = 11'b1_1_11000001_0;
  localparam logic [FW-1:0] F_2F = 11'b1_1_00101111_0;
`else
  localparam int FW = 10;
  localparam logic [FW-1:0] F_A5 = 10'b1_10100101_0;
  localparam logic [FW-1:0] F_07 = 10'b1_00000111_0;
  localparam logic [FW-1:0] F_3C = 10'b1_00111100_0;
  localparam logic [FW-1:0] F_5A = 10'b1_01011010_0;
  localparam logic [FW-1:0] F_C1 = 10'b1_11000001_0;
  localparam logic [FW-1:0] F_2F = 10'b1_00101111_0;
`endif
  localparam int FRAME_CYC = FW * CPB;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_busy;
  logic       tx_done;
  logic       serial_out;

  always #5 clk = ~clk;

  uart_tx_block #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .serial_out (serial_out)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int errors   = 0;
  int exp_done = 0;
  int done_cnt = 0;
  logic [FW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Raise tx_start in the current cycle; it is sampled at the next edge.
  task automatic start_now(input logic [7:0] d, input logic [FW-1:0] f, input bit push);
    tx_data  = d;
    tx_start = 1'b1;
    if (push) begin
      exp_q.push_back(f);
      exp_done++;
    end
    @(posedge clk); #1;
    tx_start = 1'b0;
    check("start_latency", {30'd0, tx_busy, serial_out}, 32'b10);
  endtask

  task automatic send(input logic [7:0] d, input logic [FW-1:0] f, input bit push);
    @(posedge clk); #1;
    start_now(d, f, push);
  endtask

  // Returns #1 after the edge at which tx_done rose.
  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < FRAME_CYC + 20; i++) begin
      @(posedge clk); #1;
      if (tx_done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", {31'd0, got}, 32'd1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (n_rst && tx_done) done_cnt++;
  end

  initial begin : line_monitor
    logic          prev;
    logic [FW-1:0] obs;
    bit            stable;
    bit            busy_ok;
    bit            abort;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        prev = 1'b1;
        continue;
      end
      if (prev && !serial_out) begin
        obs     = '0;
        stable  = 1'b1;
        busy_ok = 1'b1;
        abort   = 1'b0;
        for (int k = 0; k < FRAME_CYC; k++) begin
          if (k > 0) @(negedge clk);
          if (!n_rst) begin
            abort = 1'b1;
            break;
          end
          if (k % CPB == 0) obs[k / CPB] = serial_out;
          else if (serial_out !== obs[k / CPB]) stable = 1'b0;
          if (tx_busy !== 1'b1) busy_ok = 1'b0;
        end
        if (!abort) begin
          check("bit_stable", {31'd0, stable}, 32'd1);
          check("busy_in_frame", {31'd0, busy_ok}, 32'd1);
          @(negedge clk);
          check("done_after_stop", {29'd0, tx_done, tx_busy, serial_out}, 32'b101);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %0h expected none", obs);
          end else begin
            check("frame", 32'(obs), 32'(exp_q.pop_front()));
          end
        end
      end
      prev = serial_out;
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    bit quiet;
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_serial", {31'd0, serial_out}, 32'd1);
    check("rst_busy",   {31'd0, tx_busy},    32'd0);
    check("rst_done",   {31'd0, tx_done},    32'd0);
    n_rst = 1'b1;

    // Idle with tx_start low: no line activity.
    quiet = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      if (serial_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) quiet = 1'b0;
    end
    check("idle_quiet", {31'd0, quiet}, 32'd1);

    // Plain frames.
    send(8'hA5, F_A5, 1'b1);
    wait_done();
    send(8'h07, F_07, 1'b1);
    wait_done();

    // Mid-frame request with different data must be ignored.
    send(8'h3C, F_3C, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    tx_data  = 8'hFF;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    check("busy_mid_frame", {31'd0, tx_busy}, 32'd1);
    wait_done();

    // Back-to-back: request in the tx_done cycle.
    send(8'h5A, F_5A, 1'b1);
    wait_done();
    start_now(8'hC1, F_C1, 1'b1);
    wait_done();

    // Reset during data bit 3 of an abandoned frame.
    send(8'h96, '0, 1'b0);
    repeat (44) @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    check("midrst_serial", {31'd0, serial_out}, 32'd1);
    check("midrst_busy",   {31'd0, tx_busy},    32'd0);
    check("midrst_done",   {31'd0, tx_done},    32'd0);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", {30'd0, tx_busy, serial_out}, 32'b01);

    // Clean full frame after reset.
    send(8'h2F, F_2F, 1'b1);
    wait_done();

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'(exp_done));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_block.md
# uart_tx_block

Serial transmitter producing 8N1-style asynchronous frames (start bit, LSB-first data, optional parity, stop bit) on a single line. It is the transmit-side counterpart of the team's serial receive path and shares its bit-period conventions. It sits between a byte-producing client (handshake via `tx_start`/`tx_busy`) and the physical serial output pin. Internally it uses one bit-period timer and one bit-index counter, both flex-style counters with rollover.

## Interface
- `CLKS_PER_BIT`, default 10: clock cycles per serial bit; must be ≥ 2.
- `DATA_BITS`, default 8: data bits per frame; legal range 5–8.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `tx_start`  in  1  request to send `tx_data`; sampled only when not busy.
- `tx_data`  in  DATA_BITS  byte to send; latched on accepted `tx_start`.
- `tx_busy`  out  1  high while a frame is in progress.
- `tx_done`  out  1  one-cycle pulse when a frame completes.
- `serial_out`  out  1  serial line; idle high.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `serial_out`=1. When `tx_start`=1, latch `tx_data` into the shift register, clear the timer and bit index, and go to START.
- START: `serial_out`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: `serial_out`=shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then the shift register shifts right. After bit DATA_BITS-1, go to PARITY if enabled, else STOP.
- PARITY: only when the parity build option is enabled (see Configuration). Hold `serial_out` for CLKS_PER_BIT cycles, then go to STOP.
- STOP: `serial_out`=1 for CLKS_PER_BIT cycles, then go to IDLE with `tx_done` pulsed.
- `tx_busy` = (state != IDLE). `tx_start` while busy is ignored; the latched data is unaffected by `tx_data` changes mid-frame.
- Bit timer: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1 and wraps.
- Bit index: $clog2(DATA_BITS) bits, advances only when the timer wraps in DATA.
- Back-to-back frames: `tx_start` sampled in the cycle `tx_done` is high is accepted, because state is IDLE. The next start bit then begins one cycle later, giving exactly one extra idle-high cycle between frames.

## Timing
- Reset values: `serial_out`=1, `tx_busy`=0, `tx_done`=0, state IDLE, counters 0, shift register 0.
- `serial_out` and `tx_done` are registered outputs; there is no combinational path from inputs.
- Accepted `tx_start` in cycle N: `serial_out` falls and `tx_busy` rises at edge N+1.
- Frame length: F = (2 + DATA_BITS + P) × CLKS_PER_BIT cycles, where P=1 with parity, else 0. `serial_out` holds each bit level for exactly CLKS_PER_BIT cycles.
- `tx_done` is high for the single cycle immediately after the last STOP cycle. `tx_busy` is 0 in that same cycle.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously). No `tx_done` is produced and no partial frame resumes after reset release.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- Defined: PARITY state is compiled in. The parity bit is even parity, i.e. the XOR of the latched data bits, computed at latch time and stored in a 1-bit register. F includes P=1.
- Undefined: the PARITY state and parity register are absent. DATA goes directly to STOP and P=0.

## Structure
- Package `uart_tx_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP). PARITY is declared unconditionally so the encoding is stable.
  - Localparam `IDLE_LEVEL`=1'b1.
- Sub-module `tx_bit_timer`: parameterised wrap counter with enable, synchronous clear, and a one-cycle wrap strobe. It is used for the bit period; the bit index may be a second instance or inline logic.
- FSM, shift register, and output registers live in `uart_tx_block`.

## Test plan
- Reset with CLKS_PER_BIT=10: `serial_out`=1, `tx_busy`=0, `tx_done`=0; `tx_start` held low for 50 cycles produces no line activity.
- `tx_start` with `tx_data`=8'hA5, no parity: line shows 0, 1,0,1,0,0,1,0,1, 1, each held exactly 10 cycles. `tx_done` pulses at cycle 101 after acceptance.
- With `UART_TX_PARITY_EN` and `tx_data`=8'h07: parity bit 1 is inserted before the stop bit; frame is 110 cycles.
- `tx_start` re-pulsed mid-frame with `tx_data`=8'hFF: ignored, and the original byte 8'h3C completes intact. A `tx_start` coinciding with `tx_done` starts the next frame after exactly one idle cycle.
- `n_rst` pulsed low during data bit 3: `serial_out`=1 immediately, no `tx_done`. A new `tx_start` afterwards sends a clean full frame.
